// File: rtl/vproc.sv
// vproc: virtual-processor bus master that writes a pattern block, reads it back, then reports status.
// Optional feature macro VPROC_BURST_IF_EN adds the Burst/BurstFirst/BurstLast block-position outputs.
`timescale 1ns/1ps
module vproc #(
    parameter int INT_WIDTH  = 3,
    parameter int NODE_WIDTH = 32,
    parameter int NUM_WORDS  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic [31:0]           Addr,
    output logic                  WE,
    output logic                  RD,
    output logic [31:0]           DataOut,
    input  logic [31:0]           DataIn,
    input  logic                  WRAck,
    input  logic                  RDAck,
    input  logic [INT_WIDTH-1:0]  Interrupt,
    output logic                  Update,
    input  logic                  UpdateResponse,
    input  logic [NODE_WIDTH-1:0] Node
`ifdef VPROC_BURST_IF_EN
    ,
    output logic [11:0]           Burst,
    output logic                  BurstFirst,
    output logic                  BurstLast
`endif
);
    localparam logic [31:0] MEM_BASE  = 32'hA000_0000;
    localparam logic [31:0] TERM_ADDR = 32'hB000_0000;
    localparam logic [10:0] LAST_IDX  = 11'(NUM_WORDS - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DONE, HALT} state_t;

    state_t               state_q, state_d;
    logic [10:0]          idx_q, idx_d;
    logic [15:0]          err_q, err_d;
    logic [15:0]          irq_q, irq_d;
    logic [INT_WIDTH-1:0] int_prev_q;
    logic [31:0]          addr_q, addr_d, dout_q, dout_d;
    logic                 we_q, we_d, rd_q, rd_d, upd_q, upd_d;

    logic        start, acked, busy, can_issue, present;
    logic [31:0] exp_data;
    logic [16:0] irq_inc, irq_sum;
    logic        unused_node;

    if (NODE_WIDTH > 16) begin : g_node_hi
        assign unused_node = ^Node[NODE_WIDTH-1:16];
    end else begin : g_node_lo
        assign unused_node = 1'b0;
    end

    assign start     = Interrupt[0] & ~int_prev_q[0];
    assign acked     = (we_q & WRAck) | (rd_q & RDAck);
    assign busy      = we_q | rd_q;
    assign can_issue = (UpdateResponse == upd_q);
    assign exp_data  = {Node[15:0], 5'b0, idx_q};

    // Higher interrupt bits only feed the status word; edges summed across bits, saturating.
    always_comb begin
        irq_inc = '0;
        for (int b = 1; b < INT_WIDTH; b++)
            irq_inc = irq_inc + 17'(Interrupt[b] & ~int_prev_q[b]);
        irq_sum = {1'b0, irq_q} + irq_inc;
        irq_d   = irq_sum[16] ? 16'hFFFF : irq_sum[15:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        we_d    = we_q;
        rd_d    = rd_q;
        upd_d   = upd_q;
        present = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    err_d   = '0;
                end
            end
            default: begin
                if (acked) begin
                    upd_d = ~upd_q;
                    we_d  = 1'b0;
                    rd_d  = 1'b0;
                    if (rd_q && DataIn != exp_data && err_q != 16'hFFFF)
                        err_d = err_q + 16'd1;
                    if (state_q == DONE) begin
                        state_d = HALT;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = (state_q == WRITE) ? READ : DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                    present = can_issue && (state_q != DONE);
                end else if (!busy) begin
                    // Either the first word of a phase or resuming after an update stall.
                    present = can_issue;
                end
            end
        endcase
        if (present) begin
            case (state_d)
                WRITE: begin
                    we_d   = 1'b1;
                    addr_d = MEM_BASE + 32'(idx_d[9:0]);
                    dout_d = {Node[15:0], 5'b0, idx_d};
                end
                READ: begin
                    rd_d   = 1'b1;
                    addr_d = MEM_BASE + 32'(idx_d[9:0]);
                end
                DONE: begin
                    we_d   = 1'b1;
                    addr_d = TERM_ADDR;
                    dout_d = {irq_q, err_d};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            err_q      <= '0;
            irq_q      <= '0;
            int_prev_q <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
            int_prev_q <= Interrupt;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            upd_q      <= upd_d;
        end
    end

    assign Addr    = addr_q;
    assign DataOut = dout_q;
    assign WE      = we_q;
    assign RD      = rd_q;
    assign Update  = upd_q;

`ifdef VPROC_BURST_IF_EN
    logic in_block;
    assign in_block   = (state_q == WRITE) || (state_q == READ);
    assign Burst      = in_block ? (12'(NUM_WORDS) - {1'b0, idx_q}) : 12'd0;
    assign BurstFirst = in_block && (idx_q == 11'd0);
    assign BurstLast  = in_block && (idx_q == LAST_IDX);
`endif
endmodule

// File: tb/tb_vproc.sv
// Bench for vproc: transaction scoreboard built from the program rules plus directed timing checks.
`timescale 1ns/1ps
module tb_vproc;
    localparam int NW = 16;

    logic        Clk, Reset;
    logic [31:0] Addr, DataOut, DataIn;
    logic        WE, RD, WRAck, RDAck, Update, UpdateResponse;
    logic [2:0]  Interrupt;
    logic [31:0] Node;
`ifdef VPROC_BURST_IF_EN
    logic [11:0] Burst;
    logic        BurstFirst, BurstLast;
`endif

    vproc #(.INT_WIDTH(3), .NODE_WIDTH(32), .NUM_WORDS(NW)) dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .WE(WE), .RD(RD), .DataOut(DataOut),
        .DataIn(DataIn), .WRAck(WRAck), .RDAck(RDAck), .Interrupt(Interrupt),
        .Update(Update), .UpdateResponse(UpdateResponse), .Node(Node)
`ifdef VPROC_BURST_IF_EN
        , .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory and handshake environment
    logic [31:0] mem [0:1023];
    int          wr_delay = 0;
    int          wr_wait  = 0;
    logic        corrupt  = 1'b0;
    logic        stall    = 1'b0;

    initial for (int k = 0; k < 1024; k++) mem[k] = '0;

    assign WRAck          = WE && (wr_wait == wr_delay);
    assign RDAck          = RD;
    assign UpdateResponse = stall ? ~Update : Update;
    assign DataIn         = mem[Addr[9:0]] ^ ((corrupt && Addr[9:0] == 10'd3) ? 32'hFFFF_0000 : 32'h0);

    always @(posedge Clk) begin
        if (Reset || !WE || WRAck) wr_wait <= 0;
        else                       wr_wait <= wr_wait + 1;
        if (WE && WRAck && Addr[31:28] == 4'hA) mem[Addr[9:0]] <= DataOut;
    end

    // Expected transaction stream
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t expq[$];

    task automatic load_program(input logic [15:0] node, input logic bad_word, input logic [15:0] irq);
        txn_t t;
        for (int k = 0; k < NW; k++) begin
            t.we = 1'b1; t.addr = 32'hA000_0000 + 32'(k); t.data = {node, 16'(k)};
            expq.push_back(t);
        end
        for (int k = 0; k < NW; k++) begin
            t.we = 1'b0; t.addr = 32'hA000_0000 + 32'(k); t.data = '0;
            expq.push_back(t);
        end
        t.we = 1'b1; t.addr = 32'hB000_0000; t.data = {irq, bad_word ? 16'd1 : 16'd0};
        expq.push_back(t);
    endtask

    // Compare process: every accepted transaction against the stream, plus per-cycle bus rules
    int          done_cnt = 0;
    logic [31:0] last_b_data = '0;
    logic [31:0] wseen [0:1023];
    logic        p_pend = 1'b0, p_we = 1'b0, p_rd = 1'b0;
    logic [31:0] p_addr = '0, p_data = '0;

    always @(negedge Clk) begin : mon
        txn_t t;
        if (Reset) begin
            p_pend = 1'b0;
        end else begin
            if (WE || RD) chk("strobe_exclusive", {31'b0, WE && RD}, 32'd0);
            if (p_pend) begin
                chk("hold_we", {31'b0, WE}, {31'b0, p_we});
                chk("hold_rd", {31'b0, RD}, {31'b0, p_rd});
                chk("hold_addr", Addr, p_addr);
                if (p_we) chk("hold_data", DataOut, p_data);
            end
            if ((WE && WRAck) || (RD && RDAck)) begin
                if (expq.size() == 0) begin
                    chk("unexpected_txn_addr", Addr, 32'hFFFF_FFFF);
                end else begin
                    t = expq.pop_front();
                    chk("txn_we", {31'b0, WE}, {31'b0, t.we});
                    chk("txn_addr", Addr, t.addr);
                    if (t.we) chk("txn_data", DataOut, t.data);
                end
                if (WE && Addr == 32'hB000_0000) begin
                    last_b_data = DataOut;
                    done_cnt++;
                end
                if (WE && Addr[31:28] == 4'hA) wseen[Addr[9:0]] = DataOut;
            end
            p_pend = (WE && !WRAck) || (RD && !RDAck);
            p_we = WE; p_rd = RD; p_addr = Addr; p_data = DataOut;
        end
    end

    task automatic do_reset(input int n);
        @(negedge Clk);
        Reset = 1'b1; Interrupt = '0; stall = 1'b0;
        repeat (n) @(negedge Clk);
        Reset = 1'b0;
        expq.delete();
    endtask

    task automatic start_prog(output int lat);
        Interrupt[0] = 1'b1;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            Interrupt[0] = 1'b0;
        end while (!WE && lat < 20);
    endtask

    task automatic wait_done(input int target, output int we_c, output int rd_c);
        int cyc;
        we_c = 0; rd_c = 0; cyc = 0;
        while (done_cnt < target && cyc < 600) begin
            @(negedge Clk);
            cyc++;
            if (WE) we_c++;
            if (RD) rd_c++;
        end
        chk("done_reached", {31'b0, done_cnt >= target}, 32'd1);
    endtask

    task automatic pulse_irq(input logic [2:0] v);
        Interrupt = v;
        @(negedge Clk);
        Interrupt = '0;
        @(negedge Clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        int lat, run, we_c, rd_c, base;
        Reset = 1'b1; Interrupt = '0; Node = '0;

        // Baseline program, Node=0, acks tied to strobes
        do_reset(5);
        chk("rst_addr", Addr, 32'h0);
        chk("rst_dout", DataOut, 32'h0);
        chk("rst_we", {31'b0, WE}, 32'd0);
        chk("rst_rd", {31'b0, RD}, 32'd0);
        chk("rst_update", {31'b0, Update}, 32'd0);
        load_program(16'h0, 1'b0, 16'h0);
        base = done_cnt;
        start_prog(lat);
        chk("start_latency", lat, 2);
        chk("first_addr", Addr, 32'hA000_0000);
        run = 1;
        for (int k = 0; k < 40 && WE; k++) begin @(negedge Clk); if (WE) run++; end
        chk("we_run", run, NW);
        chk("wr_to_rd_b2b", {31'b0, RD}, 32'd1);
        run = 1;
        for (int k = 0; k < 40 && RD; k++) begin @(negedge Clk); if (RD) run++; end
        chk("rd_run", run, NW);
        chk("rd_to_done_b2b", {31'b0, WE}, 32'd1);
        chk("done_addr", Addr, 32'hB000_0000);
        wait_done(base + 1, we_c, rd_c);
        chk("final_data_clean", last_b_data, 32'h0000_0000);
        @(negedge Clk);
        chk("halt_strobes", {30'b0, WE, RD}, 32'd0);
        chk("halt_addr_kept", Addr, 32'hB000_0000);
        chk("update_parity", {31'b0, Update}, 32'd1);
        chk("queue_empty_1", expq.size(), 0);

        // Corrupted word 3; a start edge mid-program must be ignored
        do_reset(3);
        corrupt = 1'b1;
        load_program(16'h0, 1'b1, 16'h0);
        base = done_cnt;
        start_prog(lat);
        pulse_irq(3'b001);
        wait_done(base + 1, we_c, rd_c);
        chk("final_data_corrupt", last_b_data, 32'h0000_0001);
        repeat (5) @(negedge Clk);
        chk("no_restart_strobes", {30'b0, WE, RD}, 32'd0);
        chk("done_once", done_cnt - base, 1);
        corrupt = 1'b0;

        // Node seed, irq counting, restart from HALT
        do_reset(3);
        Node = 32'h0000_1234;
        pulse_irq(3'b010);
        pulse_irq(3'b110);
        load_program(16'h1234, 1'b0, 16'd3);
        base = done_cnt;
        start_prog(lat);
        wait_done(base + 1, we_c, rd_c);
        chk("node_word5", wseen[5], 32'h1234_0005);
        chk("final_data_irq", last_b_data, 32'h0003_0000);
        load_program(16'h1234, 1'b0, 16'd3);
        start_prog(lat);
        wait_done(base + 2, we_c, rd_c);
        chk("queue_empty_restart", expq.size(), 0);
        Node = '0;

        // Write acknowledge delayed two cycles
        do_reset(3);
        wr_delay = 2;
        load_program(16'h0, 1'b0, 16'h0);
        base = done_cnt;
        start_prog(lat);
        wait_done(base + 1, we_c, rd_c);
        chk("delayed_we_cycles", we_c + 1, (NW + 1) * 3);
        chk("delayed_rd_cycles", rd_c, NW);
        chk("queue_empty_delay", expq.size(), 0);
        wr_delay = 0;

        // Update handshake stalled for four edges after the first write
        do_reset(3);
        load_program(16'h0, 1'b0, 16'h0);
        base = done_cnt;
        start_prog(lat);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            chk("stall_strobes_low", {30'b0, WE, RD}, 32'd0);
        end
        stall = 1'b0;
        @(negedge Clk);
        chk("resume_we", {31'b0, WE}, 32'd1);
        chk("resume_addr", Addr, 32'hA000_0001);
        wait_done(base + 1, we_c, rd_c);
        chk("queue_empty_stall", expq.size(), 0);

        // Reset pulsed during READ, then full rerun
        do_reset(3);
        load_program(16'h0, 1'b0, 16'h0);
        start_prog(lat);
        for (int k = 0; k < 60 && !RD; k++) @(negedge Clk);
        chk("reached_read", {31'b0, RD}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_addr", Addr, 32'h0);
        chk("midrst_dout", DataOut, 32'h0);
        chk("midrst_strobes", {30'b0, WE, RD}, 32'd0);
        chk("midrst_update", {31'b0, Update}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        expq.delete();
        repeat (4) @(negedge Clk);
        chk("idle_after_rst", {30'b0, WE, RD}, 32'd0);
        load_program(16'h0, 1'b0, 16'h0);
        base = done_cnt;
        start_prog(lat);
        wait_done(base + 1, we_c, rd_c);
        chk("rerun_final", last_b_data, 32'h0000_0000);
        chk("queue_empty_rerun", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
